// File: rtl/fas_pkg.sv
// Shared types and constants for the FAS stimulus path: state encoding, sine table, widths.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fas_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int LUT_FRAC  = 14;
  localparam int PHASE_W   = 4;
  localparam int LUT_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } tone_state_t;

  // sin(2*pi*m/16) in Q2.14
  localparam logic signed [SAMPLE_W-1:0] SIN_LUT [LUT_DEPTH] = '{
    16'sd0,      16'sd6270,   16'sd11585,  16'sd15137,
    16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270,
    16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137,
    -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270
  };

  // Clamp a 32-bit signed value into the signed 16-bit sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7fff;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tone_gen_if.sv
// Request/sample bundle between a burst controller and tone_gen.
// Latency: none (wires only).
// Backpressure: none; samples are pushed with a one-cycle qualifier.
interface tone_gen_if;
  import fas_pkg::*;

  logic                       start;
  logic [PHASE_W-1:0]         freq;
  logic signed [SAMPLE_W-1:0] amp;
  logic signed [SAMPLE_W-1:0] data;
  logic                       data_valid;
  logic                       busy;
  logic                       done;

  // Burst requester side
  modport master (
    output start, freq, amp,
    input  data, data_valid, busy, done
  );

  // Tone generator side
  modport slave (
    input  start, freq, amp,
    output data, data_valid, busy, done
  );

endinterface

// File: rtl/tone_sin_rom.sv
// 16-entry Q2.14 sine ROM indexed by a 4-bit phase.
// Latency: combinational.
// Backpressure: not applicable.
module tone_sin_rom
  import fas_pkg::*;
(
  input  logic [PHASE_W-1:0]         phase,
  output logic signed [SAMPLE_W-1:0] value
);

  // Table lookup
  always_comb begin
    value = SIN_LUT[phase];
  end

endmodule

// File: rtl/tone_gen.sv
// Burst sinusoid source at 16-point FFT bin k: FRAMES*16 samples of sat16((a*SIN[k*n mod 16])>>>14).
// Latency: first sample one cycle after accepted start; done one cycle after the last sample.
// Backpressure: none; start is ignored while busy, output paced only by GAP.
module tone_gen
  import fas_pkg::*;
#(
  parameter int FRAMES = 64,
  parameter int GAP    = 0
) (
  input logic       clk,
  input logic       rst,
  tone_gen_if.slave bus
);

  localparam int N_SAMPLES = FRAMES * 16;
  localparam int N_W       = $clog2(N_SAMPLES);
  localparam int GAP_W     = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [N_W-1:0]   LAST_N   = N_W'(N_SAMPLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  tone_state_t                state_q, state_d;
  logic [PHASE_W-1:0]         k_q, k_d;
  logic signed [SAMPLE_W-1:0] a_q, a_d;
  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic [N_W-1:0]             n_q, n_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic signed [SAMPLE_W-1:0] data_q;
  logic                       valid_q, valid_d;
  logic                       load_d;

  logic signed [SAMPLE_W-1:0] sin_val;
  logic signed [31:0]         a_ext;
  logic signed [31:0]         s_ext;
  logic signed [31:0]         prod;
  logic signed [31:0]         shifted;
  logic signed [SAMPLE_W-1:0] sample_d;

  // The sample is computed from the phase/amplitude the next cycle will use,
  // so that data lands on a flop in the same cycle data_valid is high.
  tone_sin_rom u_rom (
    .phase (phase_d),
    .value (sin_val)
  );

  // Multiply, floor-shift back to sample scale, then clamp
  always_comb begin
    a_ext    = 32'(a_d);
    s_ext    = 32'(sin_val);
    prod     = a_ext * s_ext;
    shifted  = prod >>> LUT_FRAC;
    sample_d = sat16(shifted);
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    phase_d = phase_q;
    n_d     = n_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          k_d     = bus.freq;
          a_d     = bus.amp;
          phase_d = '0;
          n_d     = '0;
          gap_d   = '0;
          state_d = ST_RUN;
          valid_d = 1'b1;
          load_d  = 1'b1;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        phase_d = phase_q + k_q;
        n_d     = n_q + 1'b1;
        if (n_q == LAST_N) begin
          state_d = ST_DONE;
          n_d     = '0;
        end else if (GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end else begin
          valid_d = 1'b1;
          load_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_RUN;
          gap_d   = '0;
          valid_d = 1'b1;
          load_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered sample output; data holds between samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      phase_q <= '0;
      n_q     <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      phase_q <= phase_d;
      n_q     <= n_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      if (load_d) begin
        data_q <= sample_d;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_GAP);
  assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: one instance with FRAMES=1/GAP=0, one with FRAMES=4/GAP=2.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected samples come from hand-computed tables.
module tb_tone_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tone_gen_if bus_a ();
  tone_gen_if bus_b ();

  tone_gen #(.FRAMES(1), .GAP(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  tone_gen #(.FRAMES(4), .GAP(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  localparam logic signed [15:0] EXP_F1 [16] = '{
    16'sd0, 16'sd6270, 16'sd11585, 16'sd15137, 16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270,
    16'sd0, -16'sd6270, -16'sd11585, -16'sd15137, -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270
  };
  localparam logic signed [15:0] EXP_F2 [8] = '{
    16'sd0, 16'sd11585, 16'sd16384, 16'sd11585, 16'sd0, -16'sd11585, -16'sd16384, -16'sd11585
  };
  localparam logic signed [15:0] EXP_SAT [4] = '{16'sd0, 16'sh8000, 16'sd0, 16'sh7fff};

  task automatic test_reset;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.freq = 4'd0; bus_a.amp = 16'sd0;
    bus_b.start = 1'b0; bus_b.freq = 4'd0; bus_b.amp = 16'sd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.data, bus_a.data_valid, bus_a.busy, bus_a.done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_a data=%0d valid=%0b busy=%0b done=%0b want all 0",
               bus_a.data, bus_a.data_valid, bus_a.busy, bus_a.done);
    end
    checks++;
    if ({bus_b.data, bus_b.data_valid, bus_b.busy, bus_b.done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_b data=%0d valid=%0b busy=%0b done=%0b want all 0",
               bus_b.data, bus_b.data_valid, bus_b.busy, bus_b.done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.data, bus_a.data_valid, bus_a.busy, bus_a.done} !== 19'd0) begin
      errors++;
      $display("FAIL idle_after_reset data=%0d valid=%0b busy=%0b done=%0b want all 0",
               bus_a.data, bus_a.data_valid, bus_a.busy, bus_a.done);
    end
  endtask

  // freq=1 sine, a mid-burst start that must be ignored, and a start in the DONE cycle
  task automatic test_sine;
    @(negedge clk);
    bus_a.freq = 4'd1; bus_a.amp = 16'sd16384; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        bus_a.start = 1'b1; bus_a.freq = 4'd3; bus_a.amp = 16'sd100;
      end
      if (i == 6) bus_a.start = 1'b0;
      checks++;
      if (bus_a.data_valid !== 1'b1 || bus_a.data !== EXP_F1[i] || bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin
        errors++;
        $display("FAIL sine_f1 i=%0d data=%0d valid=%0b busy=%0b done=%0b want data=%0d valid=1 busy=1 done=0",
                 i, bus_a.data, bus_a.data_valid, bus_a.busy, bus_a.done, EXP_F1[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.data_valid !== 1'b0 || bus_a.data !== -16'sd6270) begin
      errors++;
      $display("FAIL sine_done done=%0b busy=%0b valid=%0b data=%0d want done=1 busy=0 valid=0 data=-6270",
               bus_a.done, bus_a.busy, bus_a.data_valid, bus_a.data);
    end
    bus_a.start = 1'b1; bus_a.freq = 4'd2; bus_a.amp = 16'sd16384;
    @(negedge clk);
    bus_a.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus_a.data_valid !== 1'b1 || bus_a.data !== EXP_F2[i % 8] || bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin
        errors++;
        $display("FAIL done_restart i=%0d data=%0d valid=%0b busy=%0b done=%0b want data=%0d valid=1 busy=1 done=0",
                 i, bus_a.data, bus_a.data_valid, bus_a.busy, bus_a.done, EXP_F2[i % 8]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_done done=%0b busy=%0b want done=1 busy=0", bus_a.done, bus_a.busy);
    end
    @(negedge clk);
    checks++;
    if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.data_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_single_pulse done=%0b busy=%0b valid=%0b want 0 0 0",
               bus_a.done, bus_a.busy, bus_a.data_valid);
    end
  endtask

  // freq=4 with amp=-32768 reaches both rails, including the positive clamp
  task automatic test_sat;
    @(negedge clk);
    bus_a.freq = 4'd4; bus_a.amp = 16'sh8000; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus_a.data_valid !== 1'b1 || bus_a.data !== EXP_SAT[i % 4] || bus_a.busy !== 1'b1) begin
        errors++;
        $display("FAIL sat i=%0d data=%0d valid=%0b busy=%0b want data=%0d valid=1 busy=1",
                 i, bus_a.data, bus_a.data_valid, bus_a.busy, EXP_SAT[i % 4]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL sat_done done=%0b busy=%0b want done=1 busy=0", bus_a.done, bus_a.busy);
    end
    @(negedge clk);
  endtask

  // Bins 0 and 8 give all-zero samples with the normal sample count
  task automatic test_zero;
    logic [3:0] fl [2] = '{4'd0, 4'd8};
    for (int f = 0; f < 2; f++) begin
      int cnt = 0;
      int nz = 0;
      int dn = 0;
      @(negedge clk);
      bus_a.freq = fl[f]; bus_a.amp = 16'sd12345; bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (bus_a.data_valid === 1'b1) begin
          cnt++;
          if (bus_a.data !== 16'sd0) nz++;
        end
        if (bus_a.done === 1'b1) dn++;
        @(negedge clk);
      end
      checks++;
      if (cnt != 16 || nz != 0 || dn != 1) begin
        errors++;
        $display("FAIL zero_bin freq=%0d valid_count=%0d nonzero=%0d done_count=%0d want 16 0 1",
                 fl[f], cnt, nz, dn);
      end
    end
  endtask

  // GAP=2 instance: valid every third cycle, data held through gaps, 64 samples
  task automatic test_gap;
    @(negedge clk);
    bus_b.freq = 4'd2; bus_b.amp = 16'sd16384; bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    for (int c = 0; c < 190; c++) begin
      logic             ev;
      logic signed [15:0] ed;
      ev = ((c % 3) == 0);
      ed = EXP_F2[(c / 3) % 8];
      checks++;
      if (bus_b.data_valid !== ev || bus_b.data !== ed || bus_b.busy !== 1'b1 || bus_b.done !== 1'b0) begin
        errors++;
        $display("FAIL gap c=%0d data=%0d valid=%0b busy=%0b done=%0b want data=%0d valid=%0b busy=1 done=0",
                 c, bus_b.data, bus_b.data_valid, bus_b.busy, bus_b.done, ed, ev);
      end
      @(negedge clk);
    end
    checks++;
    if (bus_b.done !== 1'b1 || bus_b.busy !== 1'b0 || bus_b.data_valid !== 1'b0 || bus_b.data !== -16'sd11585) begin
      errors++;
      $display("FAIL gap_done done=%0b busy=%0b valid=%0b data=%0d want done=1 busy=0 valid=0 data=-11585",
               bus_b.done, bus_b.busy, bus_b.data_valid, bus_b.data);
    end
    @(negedge clk);
  endtask

  // Reset at sample 37 clears outputs at once, no done, then a clean burst follows
  task automatic test_reset_mid;
    int  cnt = 0;
    bit  hit = 0;
    int  dn = 0;
    @(negedge clk);
    bus_b.freq = 4'd1; bus_b.amp = 16'sd16384; bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (bus_b.data_valid === 1'b1) begin
        if (cnt == 37) hit = 1;
        else begin
          cnt++;
          @(negedge clk);
        end
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!hit || bus_b.data !== EXP_F1[37 % 16]) begin
      errors++;
      $display("FAIL reach_sample37 reached=%0b data=%0d want reached=1 data=%0d", hit, bus_b.data, EXP_F1[37 % 16]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_b.data, bus_b.data_valid, bus_b.busy, bus_b.done} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset data=%0d valid=%0b busy=%0b done=%0b want all 0",
               bus_b.data, bus_b.data_valid, bus_b.busy, bus_b.done);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus_b.done === 1'b1) dn++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus_b.done === 1'b1 || bus_b.data_valid === 1'b1) dn++;
    end
    checks++;
    if (dn != 0 || bus_b.busy !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_burst spurious_activity=%0d busy=%0b want 0 0", dn, bus_b.busy);
    end
    test_gap();
  endtask

  initial begin
    test_reset();
    test_sine();
    test_sat();
    test_zero();
    test_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Stimulus transmitter for the FAS data input: produces a signed 16-bit sinusoid stream on data/data_valid at a chosen 16-point FFT bin. It is the inverse of the analyze stage, which recovers freq from the spectrum.
- Drives the FIR input port directly, or runs as a synthesisable self-test source in front of the FAS top.
- Each burst is a fixed number of 16-sample frames; start/busy/done handshake.

Parameters:
- FRAMES, 64, number of 16-sample frames per burst (burst length = FRAMES*16 samples)
- GAP, 0, idle cycles inserted between consecutive valid samples (0 = one sample per clock)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  burst request, sampled only while busy=0
- freq  input  4  bin index k, latched on accepted start
- amp  input  16  signed amplitude, latched on accepted start
- data  output  16  signed sample, Q-format matches the FIR data input
- data_valid  output  1  data qualifier, one cycle per sample
- busy  output  1  high from the cycle after an accepted start until the last sample cycle, inclusive
- done  output  1  one-cycle pulse in the cycle after the last sample

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. While rst is high: data=0, data_valid=0, busy=0, done=0, state=IDLE, all counters=0.
- States: IDLE, RUN, GAP, DONE.
- IDLE: when start=1, latch k=freq and a=amp, clear phase and sample counter, then go to RUN.
- RUN: assert data_valid for one cycle with the sample for index n; then phase <= phase+k (4-bit wrap, mod 16) and n <= n+1.
- RUN exit: if n was the last sample (FRAMES*16-1), go to DONE. Otherwise go to GAP when GAP>0, or stay in RUN when GAP=0.
- GAP: hold data_valid=0 and data at its last value for exactly GAP cycles, then return to RUN.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start seen in the DONE cycle is accepted, so the next cycle is RUN.
- Latency: start accepted at cycle t gives the first data_valid at t+1. With GAP=0, valid samples occupy t+1 .. t+FRAMES*16 and done pulses at t+FRAMES*16+1.
- Sample value: data(n) = sat16((a * SIN[(k*n) mod 16]) >>> 14).
  - SIN is a 16-entry signed Q2.14 table of sin(2*pi*m/16): 0, 6270, 11585, 15137, 16384, 15137, 11585, 6270, 0, -6270, ...
  - The product is 32-bit signed. The shift is arithmetic, so the result floors toward -inf.
  - sat16 clamps to [-32768, 32767]. Only a=-32768 with SIN=-16384 reaches this clamp.
- data is registered, so the output sits directly on a flop. It is 0 outside bursts until the first sample.
- start while busy=1 is ignored. freq and amp changes mid-burst have no effect.
- k=0 yields all-zero samples. k=8 alternates phase 0/8, also all zeros. Both are legal.
- Reset asserted mid-burst: outputs clear immediately (asynchronously), the burst is abandoned, and done is not pulsed.
- Sample counter width: clog2(FRAMES*16). GAP counter width: clog2(GAP+1), minimum 1 bit.

Decomposition:
- Shared package fas_pkg holds:
  - state enum
  - the SIN_LUT Q2.14 constant array
  - width constants: sample width 16, LUT fraction bits 14, phase width 4
- One natural sub-module: tone_sin_rom, a combinational 16x16 ROM with 4-bit phase in and signed 16-bit value out.
- Multiply, shift, saturate and the FSM stay in tone_gen.

Test Plan:
- FRAMES=1, GAP=0, freq=1, amp=16384 -> 16 valid samples 0, 6270, 11585, 15137, 16384, 15137, 11585, 6270, 0, -6270, ..., -6270; done exactly 17 cycles after start.
- freq=4, amp=-32768 -> repeating 0, -32768, 0, 32767 (saturated); busy high for the full burst.
- freq=0 and freq=8, amp=12345 -> every sample 0; data_valid count = FRAMES*16.
- GAP=2, freq=2, amp=16384 -> data_valid every 3rd cycle carrying 0, 11585, 16384, 11585, 0, ...; data held through gaps; done one cycle after the final sample.
- start pulsed again mid-burst with a different freq -> ignored; sequence unchanged. start in the DONE cycle -> new burst's first sample on the next cycle.
- rst asserted at sample 37 -> outputs 0 asynchronously, no done pulse; after release, a new start produces a full clean burst.
